// File: rtl/multiport_regfile.sv
// RV32 integer register file: NUM_RD async read ports, NUM_WR sync write ports, x0 hardwired to 0,
// and a per-register busy scoreboard. Optional same-cycle write-to-read bypass under REGFILE_BYPASS_EN.
module multiport_regfile #(
  parameter  int XLEN   = 32,
  parameter  int NREGS  = 32,
  parameter  int NUM_RD = 2,
  parameter  int NUM_WR = 2,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*AW-1:0]     rd_addr_i,
  output logic [NUM_RD*XLEN-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*AW-1:0]     wr_addr_i,
  input  logic [NUM_WR*XLEN-1:0]   wr_data_i,
  input  logic                     alloc_en_i,
  input  logic [AW-1:0]            alloc_addr_i,
  output logic                     alloc_ready_o,
  output logic                     wr_conflict_o
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             conflict_q;
  logic             conflict_d;

  logic [NREGS-1:0] wr_hit;
  logic [XLEN-1:0]  wr_win [NREGS];
  logic             alloc_acc;

  // Per-register write decode; later ports overwrite earlier ones so the highest index wins.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      wr_hit[r] = 1'b0;
      wr_win[r] = '0;
      for (int w = 0; w < NUM_WR; w++) begin
        logic match;
        match = wr_en_i[w] && (wr_addr_i[w*AW +: AW] == AW'(r)) && (r != 0);
        wr_hit[r] = wr_hit[r] | match;
        wr_win[r] = match ? wr_data_i[w*XLEN +: XLEN] : wr_win[r];
      end
    end
  end

  // Same-register multi-write detection; writes to x0 have no effect so they never conflict.
  always_comb begin
    conflict_d = conflict_q;
    for (int a = 0; a < NUM_WR; a++) begin
      for (int b = a + 1; b < NUM_WR; b++) begin
        conflict_d = conflict_d |
                     (wr_en_i[a] && wr_en_i[b] &&
                      (wr_addr_i[a*AW +: AW] == wr_addr_i[b*AW +: AW]) &&
                      (wr_addr_i[a*AW +: AW] != '0));
      end
    end
  end

  // Allocation handshake: a busy target is only re-issuable when its write-back lands this cycle.
  always_comb begin
    alloc_ready_o = !rst_n || (alloc_addr_i == '0) || !busy_q[alloc_addr_i] || wr_hit[alloc_addr_i];
    alloc_acc     = rst_n && alloc_en_i && alloc_ready_o && (alloc_addr_i != '0);
  end

  // Next-state for array and scoreboard; a same-cycle alloc overrides the write-back clear.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      regs_d[r] = wr_hit[r] ? wr_win[r] : regs_q[r];
      if (alloc_acc && (alloc_addr_i == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if (wr_hit[r]) begin
        busy_d[r] = 1'b0;
      end else begin
        busy_d[r] = busy_q[r];
      end
    end
    busy_d[0] = 1'b0;
  end

  // State registers; reset clears everything, which discards pending busy bits immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign wr_conflict_o = conflict_q;

  // Read ports; outputs are forced quiet while reset is held.
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rdat;
      logic            rbusy;
      ra    = rd_addr_i[k*AW +: AW];
      rdat  = regs_q[ra];
      rbusy = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
      // Forward the winning write so decode sees write-back data in the same cycle.
      if (wr_hit[ra]) begin
        rdat  = wr_win[ra];
        rbusy = busy_d[ra];
      end else begin
        rdat  = regs_q[ra];
        rbusy = busy_q[ra];
      end
`endif
      if (rst_n) begin
        rd_data_o[k*XLEN +: XLEN] = rdat;
        rd_busy_o[k]              = rbusy;
      end else begin
        rd_data_o[k*XLEN +: XLEN] = '0;
        rd_busy_o[k]              = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multiport_regfile.sv
// Directed table-driven bench for multiport_regfile (default parameters, 2R/2W).
module tb_multiport_regfile;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        alloc_en;
  logic [4:0]  alloc_addr;
  logic        alloc_ready;
  logic        wr_conflict;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [1:0]  wen;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        aen;
    logic [4:0]  aa;
    logic [4:0]  ra0, ra1;
    logic [31:0] e0, e1;
    logic [1:0]  eb;
    logic        er, ec;
  } vec_t;

  vec_t vecs[$];

  multiport_regfile dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .rd_busy_o    (rd_busy),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .alloc_en_i   (alloc_en),
    .alloc_addr_i (alloc_addr),
    .alloc_ready_o(alloc_ready),
    .wr_conflict_o(wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [1:0] eb, input logic er, input logic ec);
    chk({tag, " rd0"}, rd_data[31:0], e0);
    chk({tag, " rd1"}, rd_data[63:32], e1);
    chk({tag, " busy"}, {30'd0, rd_busy}, {30'd0, eb});
    chk({tag, " ready"}, {31'd0, alloc_ready}, {31'd0, er});
    chk({tag, " conflict"}, {31'd0, wr_conflict}, {31'd0, ec});
  endtask

  task automatic idle();
    wr_en = 2'b00; wr_addr = 10'd0; wr_data = 64'd0;
    alloc_en = 1'b0; alloc_addr = 5'd0;
  endtask

  task automatic apply(input vec_t v);
    wr_en = v.wen; wr_addr = {v.wa1, v.wa0}; wr_data = {v.wd1, v.wd0};
    alloc_en = v.aen; alloc_addr = v.aa; rd_addr = {v.ra1, v.ra0};
  endtask

  initial begin
    // wen wa0 wa1 wd0 wd1 aen aa ra0 ra1 | e0 e1 eb er ec  (pre-edge expectations)
    vecs.push_back('{2'b11, 5'd3, 5'd0, 32'hDEADBEEF, 32'h1, 1'b0, 5'd0, 5'd3, 5'd0,
                     BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 2'b00, 1'b1, 1'b0});
    vecs.push_back('{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0,
                     32'hDEADBEEF, 32'h0, 2'b00, 1'b1, 1'b0});
    vecs.push_back('{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd3,
                     32'h0, 32'hDEADBEEF, 2'b00, 1'b1, 1'b0});
    vecs.push_back('{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd3,
                     32'h0, 32'hDEADBEEF, 2'b01, 1'b0, 1'b0});
    vecs.push_back('{2'b01, 5'd7, 5'd0, 32'h55, 32'h0, 1'b0, 5'd7, 5'd7, 5'd3,
                     BYP ? 32'h55 : 32'h0, 32'hDEADBEEF, BYP ? 2'b00 : 2'b01, 1'b1, 1'b0});
    vecs.push_back('{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd3,
                     32'h55, 32'hDEADBEEF, 2'b00, 1'b1, 1'b0});
    vecs.push_back('{2'b10, 5'd0, 5'd7, 32'h0, 32'hAA, 1'b1, 5'd7, 5'd7, 5'd7,
                     BYP ? 32'hAA : 32'h55, BYP ? 32'hAA : 32'h55, 2'b11, 1'b1, 1'b0});
    vecs.push_back('{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd7, 5'd7, 5'd3,
                     32'hAA, 32'hDEADBEEF, 2'b01, 1'b0, 1'b0});
    vecs.push_back('{2'b11, 5'd9, 5'd9, 32'h11, 32'h22, 1'b0, 5'd0, 5'd9, 5'd7,
                     BYP ? 32'h22 : 32'h0, 32'hAA, 2'b10, 1'b1, 1'b0});
    vecs.push_back('{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd7,
                     32'h22, 32'hAA, 2'b10, 1'b1, 1'b1});
    vecs.push_back('{2'b01, 5'd7, 5'd0, 32'h33, 32'h0, 1'b0, 5'd0, 5'd7, 5'd9,
                     BYP ? 32'h33 : 32'hAA, 32'h22, BYP ? 2'b00 : 2'b01, 1'b1, 1'b1});
    vecs.push_back('{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd9,
                     32'h33, 32'h22, 2'b00, 1'b1, 1'b1});
    vecs.push_back('{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0,
                     32'h0, 32'h0, 2'b00, 1'b1, 1'b1});
    vecs.push_back('{2'b11, 5'd0, 5'd5, 32'hFF, 32'h5A, 1'b0, 5'd0, 5'd0, 5'd5,
                     32'h0, BYP ? 32'h5A : 32'h0, 2'b00, 1'b1, 1'b1});
    vecs.push_back('{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd5,
                     32'h0, 32'h5A, 2'b00, 1'b1, 1'b1});

    rst_n = 1'b0;
    idle();
    rd_addr = {5'd5, 5'd5};
    #3;
    chk_all("in_reset", 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_all("post_reset", 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      apply(vecs[i]);
      #2;
      chk_all($sformatf("v%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].eb, vecs[i].er, vecs[i].ec);
    end

    // Reset mid-stream: build busy[4]=1 / reg4=0x99, then pull rst_n low between edges.
    @(posedge clk);
    #1;
    idle();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h99};
    alloc_en = 1'b1; alloc_addr = 5'd4;
    rd_addr = {5'd9, 5'd4};
    @(posedge clk);
    #1;
    idle();
    #2;
    chk_all("pre_rst", 32'h99, 32'h22, 2'b01, 1'b1, 1'b1);
    chk("pre_rst ready_busy4", {31'd0, (alloc_ready)}, {31'd0, 1'b1});
    rst_n = 1'b0;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h77};
    alloc_en = 1'b1; alloc_addr = 5'd4;
    #1;
    chk_all("mid_rst", 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk_all("mid_rst_edge", 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    #1;
    chk_all("after_rst", 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk_all("after_rst_edge", 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/multiport_regfile.md
# multiport_regfile

Parametrised integer register file for the next-generation RV32 core. It supports a configurable number of asynchronous read ports and synchronous write ports, and hardwires x0 to zero. A per-register busy scoreboard tracks writes that have been issued but not yet written back, so issue logic can detect RAW hazards against long-latency units. It sits between decode/issue and the write-back stage.

## Interface
- XLEN, 32, data width of each register
- NREGS, 32, register count; power of two, ≥ 2; AW = $clog2(NREGS)
- NUM_RD, 2, number of read ports (1..6)
- NUM_WR, 2, number of write ports (1..3)

- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset; asynchronous, active-low
- rd_addr_i  in  NUM_RD*AW  read addresses; port k occupies bits [k*AW +: AW]
- rd_data_o  out  NUM_RD*XLEN  read data; combinational
- rd_busy_o  out  NUM_RD  busy bit of the addressed register; combinational
- wr_en_i  in  NUM_WR  write enables
- wr_addr_i  in  NUM_WR*AW  write addresses
- wr_data_i  in  NUM_WR*XLEN  write data
- alloc_en_i  in  1  issue request; marks alloc_addr_i busy
- alloc_addr_i  in  AW  destination register being issued
- alloc_ready_o  out  1  allocation will be accepted this cycle
- wr_conflict_o  out  1  sticky flag: two write ports targeted the same register in the same cycle

## Operation
- Register array: NREGS x XLEN. Register 0 is never written. Reads of register 0 return 0 with busy = 0.
- Write: on posedge, for each port w with wr_en_i[w] = 1 and addr ≠ 0, the register takes wr_data_i[w]. The same write clears busy[addr].
- Same-address multi-write: the highest-indexed enabled port wins the data. wr_conflict_o is set the following cycle and stays set until reset.
- A write to a non-busy register is legal; busy stays 0.
- Allocation: alloc_ready_o = (alloc_addr_i == 0) | !busy[alloc_addr_i] | (some enabled write targets alloc_addr_i this cycle).
  - alloc_en_i & alloc_ready_o & addr ≠ 0 sets busy[addr] at posedge.
  - alloc_en_i with alloc_ready_o = 0 is ignored and leaves no state change. Issue logic must hold the request and retry.
  - alloc to register 0 is accepted and has no effect.
- Simultaneous write-clear and alloc on the same register: the alloc wins, so busy = 1 after the edge and the register holds the new data.
- Reads: rd_data_o[k] = reg[rd_addr_i[k]] and rd_busy_o[k] = busy[rd_addr_i[k]], subject to bypass (see Configuration).

## Timing
- Reset (async assert, sync-safe deassert external): all registers are 0, all busy bits 0, wr_conflict_o = 0. While rst_n = 0, rd_data_o = 0, rd_busy_o = 0, and alloc_ready_o = 1.
- Write latency: data appears on reads the cycle after the write edge; with bypass, it appears in the same cycle.
- Busy set: visible on rd_busy_o starting the cycle after the alloc edge.
- Reset asserted mid-operation: pending busy bits are discarded immediately. No write completes on an edge where rst_n = 0.
- No read-port or alloc back-pressure exists beyond alloc_ready_o. All outputs are combinational except wr_conflict_o, which is registered.

## Configuration
- REGFILE_BYPASS_EN defined: if an enabled write (addr ≠ 0) in the current cycle matches rd_addr_i[k], then rd_data_o[k] = the winning port's wr_data_i and rd_busy_o[k] = 0 (or 1 if a same-cycle accepted alloc targets it). This removes the write-back → decode hazard.
- Undefined: reads return the array contents only. The caller sees the new value one cycle after the write, and busy is shown pre-edge.

## Test plan
- Reset then read all ports at addr 5 -> data 0, busy 0, alloc_ready_o 1, wr_conflict_o 0.
- Write port0 addr 3 = 0xDEADBEEF, port1 addr 0 = 0x1 -> next cycle: read 3 returns 0xDEADBEEF, read 0 returns 0. With bypass, 0xDEADBEEF is returned in the write cycle itself.
- Alloc addr 7 -> busy[7] = 1. A second alloc to 7 gives alloc_ready_o 0 and is ignored. Write 7 = 0x55 -> busy 0, data 0x55.
- Same cycle: write 7 = 0xAA plus alloc 7 -> alloc_ready_o 1. After the edge, data = 0xAA and busy = 1.
- Port0 and port1 both write addr 9 (0x11, 0x22) -> reg9 = 0x22, wr_conflict_o = 1 next cycle and held until rst_n low.
- Assert rst_n mid-stream with busy[4] = 1 and reg4 = 0x99 -> immediately busy 0 and data 0. A write presented during reset is dropped.
